// File: rtl/rs_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// rs_sync_fifo_flags
//
// Single-clock FIFO for same-domain buffering. It provides an exact occupancy
// count, programmable almost-full/almost-empty thresholds, one-cycle
// overflow/underflow error pulses and a selectable read mode:
//   FWFT = 1 : first-word fall-through; the head word is always on rd_data
//              and rd acknowledges it.
//   FWFT = 0 : registered read; rd_data/rd_valid appear the cycle after an
//              accepted read, and rd_data holds its value otherwise.
//
// Ports
//   clk          in   sole clock, all logic on posedge
//   reset_n      in   synchronous active-low reset (priority over all else)
//   wr           in   write request
//   wr_data      in   write data [DATASIZE]
//   full         out  level == FIFO_DEPTH
//   almost_full  out  level >= AFULL_THRESH
//   overflow     out  one-cycle pulse: write attempted while full
//   rd           in   read request
//   rd_data      out  read data [DATASIZE]
//   rd_valid     out  rd_data holds valid data
//   empty        out  level == 0
//   almost_empty out  level <= AEMPTY_THRESH
//   underflow    out  one-cycle pulse: read attempted while empty
//   level        out  occupancy 0..FIFO_DEPTH [ADDRSIZE+1]
// -----------------------------------------------------------------------------
module rs_sync_fifo_flags #(
    parameter int DATASIZE      = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 1,
    localparam int ADDRSIZE     = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr,
    input  logic [DATASIZE-1:0] wr_data,
    output logic                full,
    output logic                almost_full,
    output logic                overflow,
    input  logic                rd,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                almost_empty,
    output logic                underflow,
    output logic [ADDRSIZE:0]   level
);

    localparam logic [ADDRSIZE:0] DEPTH_L  = (ADDRSIZE + 1)'(FIFO_DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_L  = (ADDRSIZE + 1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] AEMPTY_L = (ADDRSIZE + 1)'(AEMPTY_THRESH);

    logic [DATASIZE-1:0] mem_r [FIFO_DEPTH];
    logic [ADDRSIZE-1:0] wr_addr_r;
    logic [ADDRSIZE-1:0] rd_addr_r;
    logic [ADDRSIZE:0]   level_r;
    logic [ADDRSIZE:0]   level_nxt_s;
    logic                full_r;
    logic                almost_full_r;
    logic                empty_r;
    logic                almost_empty_r;
    logic                overflow_r;
    logic                underflow_r;
    logic                wa_s;
    logic                ra_s;

    // Accept decisions use the registered flags only, so a full FIFO drops a
    // write even when a read frees a slot in the same cycle (and vice versa).
    assign wa_s = wr && !full_r;
    assign ra_s = rd && !empty_r;

    // Next occupancy: simultaneous accepted read and write leave it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({wa_s, ra_s})
            2'b10:   level_nxt_s = level_r + {{ADDRSIZE{1'b0}}, 1'b1};
            2'b01:   level_nxt_s = level_r - {{ADDRSIZE{1'b0}}, 1'b1};
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array; deliberately not reset, contents are discarded logically.
    always_ff @(posedge clk) begin
        if (reset_n && wa_s) begin
            mem_r[wr_addr_r] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and error pulses.
    // Flags are registered from the next level so they always match level_r
    // and the outputs carry no combinational path from wr or rd.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_addr_r      <= {ADDRSIZE{1'b0}};
            rd_addr_r      <= {ADDRSIZE{1'b0}};
            level_r        <= {(ADDRSIZE + 1){1'b0}};
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (wa_s) begin
                wr_addr_r <= wr_addr_r + {{(ADDRSIZE - 1){1'b0}}, 1'b1};
            end
            if (ra_s) begin
                rd_addr_r <= rd_addr_r + {{(ADDRSIZE - 1){1'b0}}, 1'b1};
            end
            level_r        <= level_nxt_s;
            full_r         <= (level_nxt_s == DEPTH_L);
            almost_full_r  <= (level_nxt_s >= AFULL_L);
            empty_r        <= (level_nxt_s == {(ADDRSIZE + 1){1'b0}});
            almost_empty_r <= (level_nxt_s <= AEMPTY_L);
            overflow_r     <= wr && full_r;
            underflow_r    <= rd && empty_r;
        end
    end

    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign empty        = empty_r;
    assign almost_empty = almost_empty_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
    assign level        = level_r;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented before the consumer asks for it.
            assign rd_data  = mem_r[rd_addr_r];
            assign rd_valid = !empty_r;
        end else begin : g_reg_read
            logic [DATASIZE-1:0] rd_data_r;
            logic                rd_valid_r;

            // Registered read port: one-cycle latency, data held between reads.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rd_data_r  <= {DATASIZE{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (ra_s) begin
                    rd_data_r  <= mem_r[rd_addr_r];
                    rd_valid_r <= 1'b1;
                end else begin
                    rd_valid_r <= 1'b0;
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_rs_sync_fifo_flags.sv
module tb_rs_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
    localparam int AEMPT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          full1, afull1, ovf1, rv1, empty1, aempty1, unf1;
    logic [DW-1:0] rdata1;
    logic [4:0]    lvl1;
    logic          full0, afull0, ovf0, rv0, empty0, aempty0, unf0;
    logic [DW-1:0] rdata0;
    logic [4:0]    lvl0;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of stored words plus the expected
    // registered-read port and error pulses.
    logic [DW-1:0] q[$];
    logic          e_ovf, e_unf, e_rv0;
    logic [DW-1:0] e_rd0;

    typedef struct {
        bit          rst_n;
        bit          wr;
        bit          rd;
        logic [7:0]  data;
        int          lvl;
        bit          full;
        bit          afull;
        bit          empty;
        bit          aempty;
        bit          ovf;
        bit          unf;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    rs_sync_fifo_flags #(
        .DATASIZE(DW), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AFULL),
        .AEMPTY_THRESH(AEMPT), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset_n(reset_n), .wr(wr), .wr_data(wr_data),
        .full(full1), .almost_full(afull1), .overflow(ovf1), .rd(rd),
        .rd_data(rdata1), .rd_valid(rv1), .empty(empty1),
        .almost_empty(aempty1), .underflow(unf1), .level(lvl1)
    );

    rs_sync_fifo_flags #(
        .DATASIZE(DW), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AFULL),
        .AEMPTY_THRESH(AEMPT), .FWFT(0)
    ) u_reg (
        .clk(clk), .reset_n(reset_n), .wr(wr), .wr_data(wr_data),
        .full(full0), .almost_full(afull0), .overflow(ovf0), .rd(rd),
        .rd_data(rdata0), .rd_valid(rv0), .empty(empty0),
        .almost_empty(aempty0), .underflow(unf0), .level(lvl0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare both DUTs.
    task automatic step(input bit r, input bit w, input bit rr, input logic [DW-1:0] d);
        bit full_m, empty_m;
        reset_n = r;
        wr      = w;
        rd      = rr;
        wr_data = d;
        if (!r) begin
            q.delete();
            e_ovf = 1'b0;
            e_unf = 1'b0;
            e_rv0 = 1'b0;
            e_rd0 = '0;
        end else begin
            full_m  = (q.size() == DEPTH);
            empty_m = (q.size() == 0);
            e_ovf   = w && full_m;
            e_unf   = rr && empty_m;
            if (rr && !empty_m) begin
                e_rd0 = q.pop_front();
                e_rv0 = 1'b1;
            end else begin
                e_rv0 = 1'b0;
            end
            if (w && !full_m) q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("level_fwft",  32'(lvl1),    32'(q.size()));
        chk("level_reg",   32'(lvl0),    32'(q.size()));
        chk("full_fwft",   32'(full1),   32'(q.size() == DEPTH));
        chk("full_reg",    32'(full0),   32'(q.size() == DEPTH));
        chk("afull_fwft",  32'(afull1),  32'(q.size() >= AFULL));
        chk("afull_reg",   32'(afull0),  32'(q.size() >= AFULL));
        chk("empty_fwft",  32'(empty1),  32'(q.size() == 0));
        chk("empty_reg",   32'(empty0),  32'(q.size() == 0));
        chk("aempty_fwft", 32'(aempty1), 32'(q.size() <= AEMPT));
        chk("aempty_reg",  32'(aempty0), 32'(q.size() <= AEMPT));
        chk("ovf_fwft",    32'(ovf1),    32'(e_ovf));
        chk("ovf_reg",     32'(ovf0),    32'(e_ovf));
        chk("unf_fwft",    32'(unf1),    32'(e_unf));
        chk("unf_reg",     32'(unf0),    32'(e_unf));
        chk("rvalid_fwft", 32'(rv1),     32'(q.size() != 0));
        if (q.size() != 0) chk("rdata_fwft", 32'(rdata1), 32'(q[0]));
        chk("rvalid_reg",  32'(rv0),     32'(e_rv0));
        chk("rdata_reg",   32'(rdata0),  32'(e_rd0));
    endtask

    task automatic add(input bit r, input bit w, input bit rr, input logic [7:0] d,
                       input int lvl, input bit f, input bit af, input bit e,
                       input bit ae, input bit o, input bit u);
        vec_t v;
        v.rst_n = r; v.wr = w; v.rd = rr; v.data = d; v.lvl = lvl;
        v.full = f; v.afull = af; v.empty = e; v.aempty = ae; v.ovf = o; v.unf = u;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: reset, fill to full, overflow, drain, underflow.
        add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'hFF, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            add(1'b1, 1'b1, 1'b0, 8'(i), i + 1, i == 15, (i + 1) >= 14, 1'b0,
                (i + 1) <= 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'hEE, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h00, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            add(1'b1, 1'b0, 1'b1, 8'h00, 15 - i, 1'b0, (15 - i) >= 14,
                (15 - i) == 0, (15 - i) <= 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].data);
            chk("tbl_level",  32'(lvl1),    32'(tbl[i].lvl));
            chk("tbl_full",   32'(full1),   32'(tbl[i].full));
            chk("tbl_afull",  32'(afull1),  32'(tbl[i].afull));
            chk("tbl_empty",  32'(empty1),  32'(tbl[i].empty));
            chk("tbl_aempty", 32'(aempty1), 32'(tbl[i].aempty));
            chk("tbl_ovf",    32'(ovf1),    32'(tbl[i].ovf));
            chk("tbl_unf",    32'(unf1),    32'(tbl[i].unf));
        end

        // Registered read of a single word, then hold.
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("a5_fwft_shown", 32'(rdata1), 32'h0000_00A5);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("a5_rvalid", 32'(rv0), 32'h1);
        chk("a5_rdata",  32'(rdata0), 32'h0000_00A5);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("a5_hold_rvalid", 32'(rv0), 32'h0);
        chk("a5_hold_rdata",  32'(rdata0), 32'h0000_00A5);

        // Simultaneous wr/rd at level 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 1'b1, 8'h20);
        chk("sim5_level", 32'(lvl1), 32'd5);
        // Simultaneous wr/rd at full.
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
        chk("at_full", 32'(full1), 32'h1);
        step(1'b1, 1'b1, 1'b1, 8'hDD);
        chk("simfull_level", 32'(lvl1), 32'd15);
        chk("simfull_ovf",   32'(ovf1), 32'h1);
        // Simultaneous wr/rd at empty.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("at_empty", 32'(empty1), 32'h1);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        chk("simempty_level", 32'(lvl1), 32'd1);
        chk("simempty_unf",   32'(unf1), 32'h1);
        chk("simempty_data",  32'(rdata1), 32'h0000_0055);
        step(1'b1, 1'b0, 1'b1, 8'h00);

        // Wrap-around streaming at level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(8'h80 + i));
            chk("wrap_level", 32'(lvl0), 32'd3);
            chk("wrap_flags", 32'({afull1, aempty1, full1, empty1}), 32'h0);
        end

        // Mid-stream reset at level 9 with wr=rd=1.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        chk("pre_rst_level", 32'(lvl1), 32'd9);
        step(1'b0, 1'b1, 1'b1, 8'h99);
        chk("rst_level", 32'(lvl1), 32'd0);
        chk("rst_empty", 32'(empty1), 32'h1);
        chk("rst_err",   32'({ovf1, unf1, ovf0, unf0}), 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("post_rst_fwft", 32'(rdata1), 32'h0000_0077);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("post_rst_reg",  32'(rdata0), 32'h0000_0077);

        // Randomised traffic with drifting write/read bias and rare resets.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            step(($urandom_range(99) >= 2),
                 ($urandom_range(99) < bias),
                 ($urandom_range(99) < (100 - bias)),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
